// File: rtl/ctrlunit_seq.sv
// ctrlunit_seq: multi-cycle accumulator CPU control sequencer.
// Drives ALU/memory strobes from state, opcode, flags and mem ack.
//
// Ports:
//   clk_i, rst_i      clock, sync active-high reset
//   op_i [OPW-1:0]    opcode from instruction register
//   flags_i [1:0]     bit0 Z, bit1 C (used in EXEC only)
//   mem_rdy_i         memory acknowledge
//   alux_o aluy_o aluop_o wr_o wm_o jmp_o wf_o ldi_o
//   mem_rd_o ir_ld_o pc_inc_o   datapath strobes
//   state_o [2:0]     FETCH=0 DECODE=1 EXEC=2 HALT=3 ERR=4
//   illegal_o         undefined-opcode pulse
//   buserr_o          sticky memory timeout flag
module ctrlunit_seq #(
  parameter int OPW      = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [OPW-1:0] op_i,
  input  logic [1:0]     flags_i,
  input  logic           mem_rdy_i,
  output logic           alux_o,
  output logic           aluy_o,
  output logic           aluop_o,
  output logic           wr_o,
  output logic           wm_o,
  output logic           jmp_o,
  output logic           wf_o,
  output logic           ldi_o,
  output logic           mem_rd_o,
  output logic           ir_ld_o,
  output logic           pc_inc_o,
  output logic [2:0]     state_o,
  output logic           illegal_o,
  output logic           buserr_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    HALT   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          buserr_q;
  logic          pend;
  logic [3:0]    opx;

  logic alux, aluy, aluop, wr, wm, jmp;
  logic wf, ldi, mem_rd, ir_ld, pc_inc, illegal;

  // Zero-extend so the 3-bit build decodes the same table.
  assign opx = 4'(op_i);

  always_comb begin
    state_d = state_q;
    pend    = 1'b0;
    alux    = 1'b0;
    aluy    = 1'b0;
    aluop   = 1'b0;
    wr      = 1'b0;
    wm      = 1'b0;
    jmp     = 1'b0;
    wf      = 1'b0;
    ldi     = 1'b0;
    mem_rd  = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      FETCH: begin
        mem_rd = 1'b1;
        pend   = 1'b1;
        if (mem_rdy_i) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        case (opx)
          4'd0, 4'd1: begin
            mem_rd = 1'b1;
            aluop  = opx[0];
            pend   = 1'b1;
            wr     = mem_rdy_i;
            wf     = mem_rdy_i;
            if (!mem_rdy_i) state_d = EXEC;
          end
          4'd2: begin
            mem_rd = 1'b1;
            alux   = 1'b1;
            pend   = 1'b1;
            wr     = mem_rdy_i;
            if (!mem_rdy_i) state_d = EXEC;
          end
          4'd3: begin
            aluy = 1'b1;
            wm   = 1'b1;
            pend = 1'b1;
            if (!mem_rdy_i) state_d = EXEC;
          end
          4'd4:  jmp = 1'b1;
          4'd5:  jmp = flags_i[0];
          4'd6:  jmp = flags_i[1];
          4'd7: begin
            alux = 1'b1;
            wr   = 1'b1;
            ldi  = 1'b1;
          end
          4'd8:  jmp = !flags_i[0];
          4'd9:  jmp = !flags_i[1];
          4'd10: ;
          4'd15: state_d = HALT;
          default: illegal = 1'b1;
        endcase
      end
      HALT: state_d = HALT;
      ERR:  state_d = ERR;
      default: state_d = FETCH;
    endcase
    // A late ack on the last allowed cycle still completes.
    if (pend && !mem_rdy_i && cnt_q == CNT_LAST)
      state_d = ERR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || mem_rdy_i || !pend)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
      if (state_d == ERR && state_q != ERR)
        buserr_q <= 1'b1;
    end
  end

  // Reset cycle silences every output, whatever the state.
  assign alux_o    = alux    & ~rst_i;
  assign aluy_o    = aluy    & ~rst_i;
  assign aluop_o   = aluop   & ~rst_i;
  assign wr_o      = wr      & ~rst_i;
  assign wm_o      = wm      & ~rst_i;
  assign jmp_o     = jmp     & ~rst_i;
  assign wf_o      = wf      & ~rst_i;
  assign ldi_o     = ldi     & ~rst_i;
  assign mem_rd_o  = mem_rd  & ~rst_i;
  assign ir_ld_o   = ir_ld   & ~rst_i;
  assign pc_inc_o  = pc_inc  & ~rst_i;
  assign illegal_o = illegal & ~rst_i;
  assign buserr_o  = buserr_q & ~rst_i;
  assign state_o   = rst_i ? 3'd0 : state_q;

endmodule

// File: tb/tb_ctrlunit_seq.sv
// tb_ctrlunit_seq: directed bench for ctrlunit_seq (OPW=4).
// Expected strobe vectors are hand-derived per cycle.
module tb_ctrlunit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] op;
  logic [1:0] flags;
  logic       rdy;
  logic alux, aluy, aluop, wr, wm, jmp, wf, ldi;
  logic mem_rd, ir_ld, pc_inc, illegal, buserr;
  logic [2:0] state_o;
  logic [12:0] outs;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [12:0] MRD  = 13'h1000;
  localparam logic [12:0] IRL  = 13'h0800;
  localparam logic [12:0] PCI  = 13'h0400;
  localparam logic [12:0] AX   = 13'h0200;
  localparam logic [12:0] AY   = 13'h0100;
  localparam logic [12:0] AOP  = 13'h0080;
  localparam logic [12:0] WR   = 13'h0040;
  localparam logic [12:0] WM   = 13'h0020;
  localparam logic [12:0] WF   = 13'h0010;
  localparam logic [12:0] JMP  = 13'h0008;
  localparam logic [12:0] LDI  = 13'h0004;
  localparam logic [12:0] ILL  = 13'h0002;
  localparam logic [12:0] BERR = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] FOK  = MRD | IRL | PCI;

  ctrlunit_seq #(.OPW(4), .WAIT_MAX(15)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .op_i      (op),
    .flags_i   (flags),
    .mem_rdy_i (rdy),
    .alux_o    (alux),
    .aluy_o    (aluy),
    .aluop_o   (aluop),
    .wr_o      (wr),
    .wm_o      (wm),
    .jmp_o     (jmp),
    .wf_o      (wf),
    .ldi_o     (ldi),
    .mem_rd_o  (mem_rd),
    .ir_ld_o   (ir_ld),
    .pc_inc_o  (pc_inc),
    .state_o   (state_o),
    .illegal_o (illegal),
    .buserr_o  (buserr)
  );

  assign outs = {mem_rd, ir_ld, pc_inc, alux, aluy, aluop,
                 wr, wm, wf, jmp, ldi, illegal, buserr};

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic [2:0] st,
                     input logic [12:0] eo);
    @(negedge clk);
    check({tag, ".state"}, 16'(state_o), 16'(st));
    check({tag, ".outs"}, 16'(outs), 16'(eo));
    @(posedge clk);
    #1;
  endtask

  // FETCH/DECODE with inverted flags, EXEC with the real ones.
  task automatic instr(input string tag,
                       input logic [3:0] o,
                       input logic [1:0] f,
                       input logic r,
                       input logic [12:0] eo);
    op = o;
    flags = ~f;
    rdy = 1'b1;
    cyc({tag, ".F"}, 3'd0, FOK);
    cyc({tag, ".D"}, 3'd1, NONE);
    flags = f;
    rdy = r;
    cyc({tag, ".E"}, 3'd2, eo);
  endtask

  initial begin
    rst = 1'b1;
    op = 4'd0;
    flags = 2'b00;
    rdy = 1'b1;
    cyc("reset", 3'd0, NONE);
    rst = 1'b0;

    instr("add0", 4'd0, 2'b00, 1'b1, MRD | WR | WF);
    instr("add1", 4'd0, 2'b00, 1'b1, MRD | WR | WF);
    instr("sub", 4'd1, 2'b00, 1'b1, MRD | AOP | WR | WF);
    instr("lda", 4'd2, 2'b00, 1'b1, MRD | AX | WR);

    op = 4'd3;
    rdy = 1'b1;
    cyc("sta.F", 3'd0, FOK);
    cyc("sta.D", 3'd1, NONE);
    rdy = 1'b0;
    repeat (4) cyc("sta.wait", 3'd2, AY | WM);
    rdy = 1'b1;
    cyc("sta.done", 3'd2, AY | WM);

    instr("jmp", 4'd4, 2'b00, 1'b0, JMP);
    instr("jz1", 4'd5, 2'b01, 1'b0, JMP);
    instr("jz0", 4'd5, 2'b00, 1'b0, NONE);
    instr("jc1", 4'd6, 2'b10, 1'b0, JMP);
    instr("jc0", 4'd6, 2'b01, 1'b0, NONE);
    instr("ldi", 4'd7, 2'b00, 1'b0, AX | WR | LDI);
    instr("jnz1", 4'd8, 2'b00, 1'b0, JMP);
    instr("jnz0", 4'd8, 2'b01, 1'b0, NONE);
    instr("jnc0", 4'd9, 2'b10, 1'b0, NONE);
    instr("nop", 4'd10, 2'b00, 1'b1, NONE);
    instr("ill12", 4'd12, 2'b00, 1'b1, ILL);
    instr("ill11", 4'd11, 2'b00, 1'b0, ILL);

    // Ack on the 15th wait cycle completes the fetch.
    op = 4'd0;
    rdy = 1'b0;
    repeat (14) cyc("wmax.F", 3'd0, MRD);
    rdy = 1'b1;
    cyc("wmax.ack", 3'd0, FOK);
    cyc("wmax.D", 3'd1, NONE);
    cyc("wmax.E", 3'd2, MRD | WR | WF);

    instr("hlt", 4'd15, 2'b00, 1'b1, NONE);
    for (int i = 0; i < 20; i++) begin
      rdy = i[0];
      cyc("halt", 3'd3, NONE);
    end
    rst = 1'b1;
    cyc("halt.rst", 3'd0, NONE);
    rst = 1'b0;

    rdy = 1'b0;
    repeat (15) cyc("to.F", 3'd0, MRD);
    cyc("to.err", 3'd4, BERR);
    rdy = 1'b1;
    cyc("err.hold1", 3'd4, BERR);
    rdy = 1'b0;
    cyc("err.hold0", 3'd4, BERR);
    rst = 1'b1;
    cyc("err.rst", 3'd0, NONE);
    rst = 1'b0;
    op = 4'd2;
    rdy = 1'b1;
    cyc("err.clr", 3'd0, FOK);

    cyc("abort.D", 3'd1, NONE);
    rdy = 1'b0;
    cyc("abort.E", 3'd2, MRD | AX);
    rst = 1'b1;
    rdy = 1'b1;
    cyc("abort.rst", 3'd0, NONE);
    rst = 1'b0;
    rdy = 1'b0;
    cyc("abort.F", 3'd0, MRD);
    rdy = 1'b1;
    cyc("abort.F2", 3'd0, FOK);
    cyc("abort.D2", 3'd1, NONE);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrlunit_seq.md
CTRLUNIT_SEQ -- requirements
Module: ctrlunit_seq

Interface
REQ-001 Parameter OPW, default 3, opcode width; legal values 3 or 4.
REQ-002 Parameter WAIT_MAX, default 15, maximum mem_rdy_i wait cycles before a bus error; must be at least 1.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 op_i  input  OPW  opcode from the instruction register; stable from DECODE until the next FETCH.
REQ-006 flags_i  input  2  status flags; bit0 Z, bit1 C.
REQ-007 mem_rdy_i  input  1  memory acknowledge for the current mem_rd_o or wm_o request.
REQ-008 alux_o, aluy_o, aluop_o  output  1 each  ALU operand and operation selects.
REQ-009 wr_o, wm_o, jmp_o, wf_o, ldi_o  output  1 each  accumulator write, memory write, PC load, status write, immediate select.
REQ-010 mem_rd_o  output  1  memory read request.
REQ-011 ir_ld_o, pc_inc_o  output  1 each  instruction register load strobe, PC increment strobe.
REQ-012 state_o  output  3  state encoding: FETCH=0, DECODE=1, EXEC=2, HALT=3, ERR=4.
REQ-013 illegal_o, buserr_o  output  1 each  one-cycle pulse on an undefined opcode; sticky flag for a memory timeout.

Function
REQ-014 The block SHALL be a Moore/Mealy FSM with states FETCH, DECODE, EXEC, HALT and ERR; outputs SHALL be decoded from state, op_i, flags_i and mem_rdy_i.
REQ-015 FETCH: mem_rd_o=1; when mem_rdy_i=1, ir_ld_o=1 and pc_inc_o=1 in that same cycle, next state DECODE; otherwise remain in FETCH.
REQ-016 DECODE: all strobes 0, one cycle, next state EXEC.
REQ-017 EXEC, ADD (op 0): mem_rd_o=1, alux_o=0, aluop_o=0; wr_o=wf_o=1 only in the cycle mem_rdy_i=1, then next state FETCH.
REQ-018 EXEC, SUB (op 1): same as ADD but with aluop_o=1.
REQ-019 EXEC, LDA (op 2): mem_rd_o=1 and alux_o=1; wr_o=1 in the mem_rdy_i cycle, then FETCH.
REQ-020 EXEC, STA (op 3): aluy_o=1 and wm_o=1, held until mem_rdy_i=1, then FETCH.
REQ-021 EXEC, JMP/JZ/JC/LDI (ops 4-7): single cycle, no memory wait, then FETCH.
REQ-022 JMP sets jmp_o=1; JZ sets jmp_o=flags_i[0]; JC sets jmp_o=flags_i[1]; LDI sets alux_o=wr_o=ldi_o=1.
REQ-023 With OPW=4, the extended opcodes SHALL behave as follows:
- 8 JNZ: jmp_o=!flags_i[0].
- 9 JNC: jmp_o=!flags_i[1].
- 10 NOP: no strobes.
- 15 HLT: next state HALT.
- 11-14: no strobes, illegal_o=1 for one cycle, then FETCH.
REQ-024 With OPW=4 and op_i[3]=0, behaviour SHALL be identical to OPW=3.
REQ-025 Flags SHALL be sampled in the EXEC cycle only.
REQ-026 Wait counter:
- Counts consecutive cycles with a memory request pending and mem_rdy_i=0.
- Clears on mem_rdy_i=1 and on each state change.
- Reaching WAIT_MAX moves the FSM to ERR with buserr_o=1.
REQ-027 A mem_rdy_i=1 in the same cycle that the counter reaches WAIT_MAX SHALL count as completion, not as an error.
REQ-028 HALT and ERR SHALL be absorbing: all strobes 0, and only rst_i exits them.
REQ-029 At most one of wr_o and wm_o SHALL be high in any cycle.
REQ-030 jmp_o, wr_o, wm_o and wf_o SHALL each be high for at most one cycle per instruction, except that wm_o is held during the STA wait.
REQ-031 mem_rdy_i SHALL be ignored in DECODE, HALT and ERR.

Reset
REQ-032 While rst_i=1 at the clock edge, the next state SHALL be FETCH, the wait counter 0 and buserr_o 0.
REQ-033 Every output SHALL be forced to 0 in any cycle where rst_i=1, regardless of state.
REQ-034 Reset asserted mid-instruction (including during a STA wait) SHALL abandon the instruction without a further strobe, and FETCH SHALL start in the first cycle after rst_i falls.

Verification
REQ-035 Reset, then mem_rdy_i=1 constantly with op_i=0 (ADD) -> sequence FETCH, DECODE, EXEC repeating, with wr_o=wf_o=1 and aluop_o=0 once per 3 cycles.
REQ-036 STA with mem_rdy_i delayed 4 cycles in EXEC -> wm_o=aluy_o=1 for 5 cycles, then FETCH, with wr_o never 1.
REQ-037 JZ with flags_i=2'b01, then flags_i=2'b00 -> jmp_o=1 in the first EXEC and 0 in the second.
REQ-038 OPW=4: op 8 with flags_i=0 -> jmp_o=1; op 12 -> illegal_o pulse and return to FETCH; op 15 -> state_o=3 held for 20 cycles despite mem_rdy_i toggling.
REQ-039 WAIT_MAX=15, mem_rdy_i held 0 in FETCH -> state_o=4 and buserr_o=1 after 15 cycles; rst_i for one cycle -> FETCH with buserr_o=0.
REQ-040 rst_i asserted during the second wait cycle of a LDA -> no wr_o, all outputs 0 in the reset cycle, and mem_rd_o=1 in FETCH the cycle after.
